// File: rtl/vscale_alu_arb.sv
// Two-requester arbiter sharing one ALU; each accepted op yields one tagged, registered response.
// Latency: one cycle from transfer to resp_valid; sustains one op per cycle while resp_ready is high.
// Backpressure: reqN_ready drops while the response buffer is full and resp_ready is low.
// Option: define VSCALE_ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.

module vscale_alu #(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic [XLEN-1:0] out
);
    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SLL  = 4'd1;
    localparam logic [3:0] ALU_OP_XOR  = 4'd4;
    localparam logic [3:0] ALU_OP_SRL  = 4'd5;
    localparam logic [3:0] ALU_OP_OR   = 4'd6;
    localparam logic [3:0] ALU_OP_AND  = 4'd7;
    localparam logic [3:0] ALU_OP_SEQ  = 4'd8;
    localparam logic [3:0] ALU_OP_SNE  = 4'd9;
    localparam logic [3:0] ALU_OP_SUB  = 4'd10;
    localparam logic [3:0] ALU_OP_SRA  = 4'd11;
    localparam logic [3:0] ALU_OP_SLT  = 4'd12;
    localparam logic [3:0] ALU_OP_SGE  = 4'd13;
    localparam logic [3:0] ALU_OP_SLTU = 4'd14;
    localparam logic [3:0] ALU_OP_SGEU = 4'd15;

    logic [4:0] shamt;
    assign shamt = in2[4:0];

    // Opcode decode; comparisons return a zero-extended single bit, unknown opcodes return 0.
    always_comb begin
        out = '0;
        case (op)
            ALU_OP_ADD:  out = in1 + in2;
            ALU_OP_SLL:  out = in1 << shamt;
            ALU_OP_XOR:  out = in1 ^ in2;
            ALU_OP_SRL:  out = in1 >> shamt;
            ALU_OP_OR:   out = in1 | in2;
            ALU_OP_AND:  out = in1 & in2;
            ALU_OP_SEQ:  out = {{(XLEN-1){1'b0}}, (in1 == in2)};
            ALU_OP_SNE:  out = {{(XLEN-1){1'b0}}, (in1 != in2)};
            ALU_OP_SUB:  out = in1 - in2;
            ALU_OP_SRA:  out = $signed(in1) >>> shamt;
            ALU_OP_SLT:  out = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
            ALU_OP_SGE:  out = {{(XLEN-1){1'b0}}, ($signed(in1) >= $signed(in2))};
            ALU_OP_SLTU: out = {{(XLEN-1){1'b0}}, (in1 < in2)};
            ALU_OP_SGEU: out = {{(XLEN-1){1'b0}}, (in1 >= in2)};
            default:     out = '0;
        endcase
    end
endmodule

module vscale_alu_arb #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic [XLEN-1:0] req0_in1,
    input  logic [XLEN-1:0] req0_in2,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic [XLEN-1:0] req1_in1,
    input  logic [XLEN-1:0] req1_in2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [XLEN-1:0] resp_data
);
    logic            can_accept;
    logic            gnt0;
    logic            gnt1;
    logic            xfer;
    logic            sel;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [XLEN-1:0] alu_out;

    logic            resp_valid_q, resp_valid_d;
    logic            resp_id_q, resp_id_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;

    // A drain and a fill may share a cycle, so a full buffer being read can still accept.
    assign can_accept = !resp_valid_q || resp_ready;

`ifdef VSCALE_ALU_ARB_RR_EN
    logic prio_q, prio_d;

    // Round-robin grant: on contention prio picks the winner, otherwise the lone valid wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (can_accept && !reset) begin
            if (req0_valid && req1_valid) begin
                gnt0 = !prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    // After a transfer, point at the port that lost (granting 0 points at 1 and vice versa).
    always_comb begin
        prio_d = prio_q;
        if (xfer) begin
            prio_d = gnt0;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    // Fixed priority grant: port 0 wins whenever it is valid; port 1 only when port 0 is idle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (can_accept && !reset) begin
            gnt0 = req0_valid;
            gnt1 = !req0_valid && req1_valid;
        end
    end
`endif

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer       = gnt0 || gnt1;
    assign sel        = gnt1;

    // Operand mux defaults to port 0 when nothing is granted; the result is then unused.
    always_comb begin
        alu_op  = req0_op;
        alu_in1 = req0_in1;
        alu_in2 = req0_in2;
        if (sel) begin
            alu_op  = req1_op;
            alu_in1 = req1_in1;
            alu_in2 = req1_in2;
        end
    end

    vscale_alu #(.XLEN(XLEN)) u_alu (
        .op  (alu_op),
        .in1 (alu_in1),
        .in2 (alu_in2),
        .out (alu_out)
    );

    // Response buffer: load on transfer, clear valid on a drain with no refill, else hold.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        if (xfer) begin
            resp_valid_d = 1'b1;
            resp_id_d    = sel;
            resp_data_d  = alu_out;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Response buffer registers; reset discards any pending result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
endmodule

// File: tb/tb_vscale_alu_arb.sv
// Bench for vscale_alu_arb: directed vectors with hand-computed results feed a scoreboard queue.
// A separate monitor pops the queue on each resp_valid && resp_ready and compares id and data.
// Also checks reset values, grant patterns, backpressure and the one-cycle latency directly.

module tb_vscale_alu_arb;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SLL  = 4'd1;
    localparam logic [3:0] OP_UND2 = 4'd2;
    localparam logic [3:0] OP_UND3 = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_SEQ  = 4'd8;
    localparam logic [3:0] OP_SNE  = 4'd9;
    localparam logic [3:0] OP_SUB  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;
    localparam logic [3:0] OP_SLT  = 4'd12;
    localparam logic [3:0] OP_SGE  = 4'd13;
    localparam logic [3:0] OP_SLTU = 4'd14;
    localparam logic [3:0] OP_SGEU = 4'd15;
    localparam int NV = 17;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_in1, req0_in2;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_in1, req1_in2;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_data;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [3:0]  v_op [NV];
    logic [31:0] v_a  [NV];
    logic [31:0] v_b  [NV];
    logic [31:0] v_e  [NV];

    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_xfer = 0;
    int   n_resp = 0;
    logic hold0 = 1'b0, hold1 = 1'b0;
    int   hidx0 = 0, hidx1 = 0;

    vscale_alu_arb #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_in1   (req0_in1),
        .req0_in2   (req0_in2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_in1   (req1_in1),
        .req1_in2   (req1_in2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e);
        v_op[i] = op; v_a[i] = a; v_b[i] = b; v_e[i] = e;
    endtask

    // One cycle of stimulus: drive after the falling edge, record transfers before the rising edge.
    task automatic step(input logic v0, input int i0, input logic v1, input int i1,
                        input logic rr, output logic t0, output logic t1);
        exp_t e;
        @(negedge clk);
        if (hold0 && (!v0 || i0 != hidx0)) begin
            n_err++;
            $display("FAIL req0_hold: valid %0b idx %0d, required held idx %0d", v0, i0, hidx0);
        end
        if (hold1 && (!v1 || i1 != hidx1)) begin
            n_err++;
            $display("FAIL req1_hold: valid %0b idx %0d, required held idx %0d", v1, i1, hidx1);
        end
        req0_valid = v0; req0_op = v_op[i0]; req0_in1 = v_a[i0]; req0_in2 = v_b[i0];
        req1_valid = v1; req1_op = v_op[i1]; req1_in1 = v_a[i1]; req1_in2 = v_b[i1];
        resp_ready = rr;
        #1;
        t0 = req0_valid && req0_ready;
        t1 = req1_valid && req1_ready;
        if (t0) begin
            e.id = 1'b0; e.data = v_e[i0]; sb_q.push_back(e); n_xfer++;
        end
        if (t1) begin
            e.id = 1'b1; e.data = v_e[i1]; sb_q.push_back(e); n_xfer++;
        end
        hold0 = v0 && !t0; hidx0 = i0;
        hold1 = v1 && !t1; hidx1 = i1;
    endtask

    // Monitor: every completed response handshake must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL resp_unexpected: got id %0b data %h, required no response", resp_id, resp_data);
                end else begin
                    e = sb_q.pop_front();
                    chk1("resp_id", resp_id, e.id);
                    chk32("resp_data", resp_data, e.data);
                    n_resp++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic t0, t1, rr, v0, v1, pv0, pv1, eg1;
        int   ix0, ix1;

        setv(0,  OP_ADD,  32'hFFFFFFFF, 32'h00000002, 32'h00000001);
        setv(1,  OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE);
        setv(2,  OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001);
        setv(3,  OP_SRA,  32'h80000000, 32'h00000004, 32'hF8000000);
        setv(4,  OP_UND2, 32'h00001234, 32'h00000001, 32'h00000000);
        setv(5,  OP_SLTU, 32'h80000000, 32'h00000001, 32'h00000000);
        setv(6,  OP_SLL,  32'h00000001, 32'h00000021, 32'h00000002);
        setv(7,  OP_SRL,  32'h80000000, 32'h0000001F, 32'h00000001);
        setv(8,  OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
        setv(9,  OP_OR,   32'h0000000F, 32'h000000F0, 32'h000000FF);
        setv(10, OP_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00);
        setv(11, OP_SEQ,  32'h00000007, 32'h00000007, 32'h00000001);
        setv(12, OP_SNE,  32'h00000007, 32'h00000007, 32'h00000000);
        setv(13, OP_SGE,  32'hFFFFFFFF, 32'h00000000, 32'h00000000);
        setv(14, OP_SGEU, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        setv(15, OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000);
        setv(16, OP_UND3, 32'h00000005, 32'h00000005, 32'h00000000);

        // Reset: outputs cleared and no grant even with both requesters valid.
        reset = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_in1 = '0; req0_in2 = '0;
        req1_valid = 1'b1; req1_op = OP_ADD; req1_in1 = '0; req1_in2 = '0;
        #12;
        chk1("reset_ready0", req0_ready, 1'b0);
        chk1("reset_ready1", req1_ready, 1'b0);
        chk1("reset_resp_valid", resp_valid, 1'b0);
        chk1("reset_resp_id", resp_id, 1'b0);
        chk32("reset_resp_data", resp_data, 32'h0);
        @(negedge clk);
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        // Contention with resp_ready high: first grant to port 0, then alternate (RR) or stay (fixed).
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1, 1'b1, 2, 1'b1, t0, t1);
`ifdef VSCALE_ALU_ARB_RR_EN
            eg1 = (i % 2 == 1);
`else
            eg1 = 1'b0;
`endif
            chk1("cont_gnt0", t0, !eg1);
            chk1("cont_gnt1", t1, eg1);
        end
        step(!t0, 1, !t1, 2, 1'b1, t0, t1);
        chk1("cont_followup_gnt", t0 | t1, 1'b1);

        // Single requester ADD with wrap; response after exactly one edge.
        step(1'b1, 0, 1'b0, 0, 1'b1, t0, t1);
        chk1("single_ready0", t0, 1'b1);
        @(posedge clk); #1;
        chk1("single_resp_valid", resp_valid, 1'b1);
        chk1("single_resp_id", resp_id, 1'b0);
        chk32("single_resp_data", resp_data, 32'h00000001);

        // Backpressure: SRA result sits in the buffer while resp_ready is low.
        step(1'b1, 3, 1'b0, 0, 1'b1, t0, t1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8, 1'b1, 9, 1'b0, t0, t1);
            chk1("bp_ready0", req0_ready, 1'b0);
            chk1("bp_ready1", req1_ready, 1'b0);
            chk32("bp_hold_data", resp_data, 32'hF8000000);
        end
        step(1'b1, 8, 1'b1, 9, 1'b1, t0, t1);
        chk1("bp_release_gnt", t0 | t1, 1'b1);
        @(posedge clk); #1;
`ifdef VSCALE_ALU_ARB_RR_EN
        chk32("bp_release_data", resp_data, 32'h000000FF);
`else
        chk32("bp_release_data", resp_data, 32'h0FF00FF0);
`endif
        step(!t0, 8, !t1, 9, 1'b1, t0, t1);
        chk1("bp_followup_gnt", t0 | t1, 1'b1);

        // Undefined opcode yields zero.
        step(1'b1, 4, 1'b0, 0, 1'b1, t0, t1);
        chk1("undef_ready0", t0, 1'b1);
        @(posedge clk); #1;
        chk1("undef_resp_valid", resp_valid, 1'b1);
        chk32("undef_resp_data", resp_data, 32'h00000000);

        // Reset mid-cycle with a result buffered: cleared at once, pending result dropped.
        step(1'b0, 0, 1'b1, 6, 1'b1, t0, t1);
        step(1'b1, 15, 1'b0, 0, 1'b1, t0, t1);
        step(1'b0, 0, 1'b0, 0, 1'b0, t0, t1);
        @(posedge clk); #3;
        chk32("pre_reset_pending", 32'(sb_q.size()), 32'd1);
        chk32("pre_reset_data", resp_data, 32'h80000000);
        reset = 1'b1;
        #1;
        chk1("midreset_resp_valid", resp_valid, 1'b0);
        chk1("midreset_resp_id", resp_id, 1'b0);
        chk32("midreset_resp_data", resp_data, 32'h0);
        n_xfer = n_xfer - sb_q.size();
        sb_q.delete();
        hold0 = 1'b0; hold1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 5, 1'b1, 7, 1'b1, t0, t1);
        chk1("post_reset_gnt0", t0, 1'b1);
        chk1("post_reset_gnt1", t1, 1'b0);

        // Randomized handshakes over the vector table; requesters hold while stalled.
        void'($urandom(32'd20240611));
        ix0 = 5; ix1 = 7; v0 = 1'b1; v1 = 1'b1;
        pv0 = 1'b0; pv1 = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!pv0) begin
                v0  = 1'($urandom_range(0, 1));
                ix0 = $urandom_range(0, NV - 1);
            end
            if (!pv1) begin
                v1  = 1'($urandom_range(0, 1));
                ix1 = $urandom_range(0, NV - 1);
            end
            rr = ($urandom_range(0, 3) != 0);
            step(v0, ix0, v1, ix1, rr, t0, t1);
            chk1("one_ready_max", req0_ready & req1_ready, 1'b0);
            pv0 = v0 && !t0;
            pv1 = v1 && !t1;
        end
        for (int c = 0; c < 4; c++) begin
            v0 = pv0; v1 = pv1;
            step(v0, ix0, v1, ix1, 1'b1, t0, t1);
            pv0 = v0 && !t0;
            pv1 = v1 && !t1;
        end
        step(1'b0, 0, 1'b0, 0, 1'b1, t0, t1);
        step(1'b0, 0, 1'b0, 0, 1'b1, t0, t1);
        #4;
        chk32("sb_empty", 32'(sb_q.size()), 32'd0);
        chk32("resp_count", 32'(n_resp), 32'(n_xfer));
        chk1("final_resp_valid", resp_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
